// File: rtl/hazard_tracker_pkg.sv
// Shared encodings for the D/E/M/W hazard tracker: forwarding selects,
// standard Tnew classes and the "operand not read" Tuse marker.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2,
        FWD_E  = 2'd3
    } fwd_sel_e;

    localparam int unsigned TNEW_JAL  = 0;
    localparam int unsigned TNEW_ALU  = 1;
    localparam int unsigned TNEW_LOAD = 2;

    localparam int unsigned TUSE_NONE = 3;

endpackage

// File: rtl/hazard_tracker_if.sv
// Decoder/datapath-facing bundle of the hazard tracker: D-stage operand
// descriptors in, stall and forwarding selects out.
interface hazard_tracker_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned TW = 2
);
    logic          flush;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic [AW-1:0] d_dst;
    logic [TW-1:0] d_tnew;
    logic          d_md_use;
    logic          d_md_start;
    logic          d_md_div;

    logic          stall;
    logic [1:0]    fwd_rs_d;
    logic [1:0]    fwd_rt_d;
    logic [1:0]    fwd_rs_e;
    logic [1:0]    fwd_rt_e;
    logic [1:0]    fwd_rt_m;
    logic          md_busy;

    modport master (
        output flush, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_use, d_md_start, d_md_div,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );

    modport slave (
        input  flush, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_use, d_md_start, d_md_div,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );
endinterface

// File: rtl/hazard_tracker_md_busy_counter.sv
// HI/LO unit busy counter: loads the mult or div latency when a start leaves E,
// then counts down to idle.
module md_busy_counter #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic isDiv,
    output logic busy
);
    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] cnt;

    // A new start reloads even if a previous operation is still counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_tracker.sv
// Tuse/Tnew scoreboard for the D/E/M/W pipeline: tracks destination records
// through E, M and W and produces the D-stage stall plus all forwarding selects.
module hazard_tracker #(
    parameter int unsigned AW          = 5,
    parameter int unsigned TW          = 2,
    parameter int unsigned TUSE_NONE   = 2**TW - 1,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    hazard_tracker_if.slave  hz
);
    import hazard_pkg::*;

    localparam logic [TW-1:0] TUSE_IDLE = TUSE_NONE[TW-1:0];

    logic [AW-1:0] eDst, eRs, eRt;
    logic [TW-1:0] eTnew;
    logic          eMdStart, eMdDiv;

    logic [AW-1:0] mDst, mRt;
    logic [TW-1:0] mTnew;

    logic [AW-1:0] wDst;

    logic          dataStall, mdStall, stall, mdBusy;
    logic [TW-1:0] eTnewDec;

    function automatic logic hits(input logic [AW-1:0] dst, input logic [AW-1:0] addr);
        return (addr != '0) && (dst == addr);
    endfunction

    // Producer in a stage blocks a D reader whose use comes before the result.
    function automatic logic stageBlocks(input logic [AW-1:0] addr, input logic [TW-1:0] tuse,
                                         input logic [AW-1:0] dst,  input logic [TW-1:0] tnew);
        return hits(dst, addr) && (tuse != TUSE_IDLE) && (tuse < tnew);
    endfunction

    function automatic logic stageReady(input logic [AW-1:0] addr,
                                        input logic [AW-1:0] dst, input logic [TW-1:0] tnew);
        return hits(dst, addr) && (tnew == '0);
    endfunction

    function automatic fwd_sel_e selD(input logic [AW-1:0] addr,
                                      input logic [AW-1:0] eD, input logic [TW-1:0] eT,
                                      input logic [AW-1:0] mD, input logic [TW-1:0] mT,
                                      input logic [AW-1:0] wD);
        if (stageReady(addr, eD, eT)) return FWD_E;
        if (stageReady(addr, mD, mT)) return FWD_M;
        if (hits(wD, addr))           return FWD_W;
        return FWD_RF;
    endfunction

    function automatic fwd_sel_e selE(input logic [AW-1:0] addr,
                                      input logic [AW-1:0] mD, input logic [TW-1:0] mT,
                                      input logic [AW-1:0] wD);
        if (stageReady(addr, mD, mT)) return FWD_M;
        if (hits(wD, addr))           return FWD_W;
        return FWD_RF;
    endfunction

    always_comb begin
        dataStall = 1'b0;
        dataStall = stageBlocks(hz.d_rs, hz.d_tuse_rs, eDst, eTnew)
                  | stageBlocks(hz.d_rs, hz.d_tuse_rs, mDst, mTnew)
                  | stageBlocks(hz.d_rt, hz.d_tuse_rt, eDst, eTnew)
                  | stageBlocks(hz.d_rt, hz.d_tuse_rt, mDst, mTnew);
    end

    assign mdStall  = hz.d_md_use && (eMdStart || mdBusy);
    assign stall    = dataStall || mdStall;
    assign eTnewDec = (eTnew == '0) ? '0 : eTnew - TW'(1);

    always_comb begin
        hz.fwd_rs_d = FWD_RF;
        hz.fwd_rt_d = FWD_RF;
        hz.fwd_rs_e = FWD_RF;
        hz.fwd_rt_e = FWD_RF;
        hz.fwd_rt_m = FWD_RF;
        hz.fwd_rs_d = selD(hz.d_rs, eDst, eTnew, mDst, mTnew, wDst);
        hz.fwd_rt_d = selD(hz.d_rt, eDst, eTnew, mDst, mTnew, wDst);
        hz.fwd_rs_e = selE(eRs, mDst, mTnew, wDst);
        hz.fwd_rt_e = selE(eRt, mDst, mTnew, wDst);
        if (hits(wDst, mRt)) hz.fwd_rt_m = FWD_W;
    end

    assign hz.stall   = stall;
    assign hz.md_busy = mdBusy;

    // Flush overrides stall: both E and M become bubbles, W still drains M.
    always_ff @(posedge clk) begin
        if (reset) begin
            eDst     <= '0;
            eRs      <= '0;
            eRt      <= '0;
            eTnew    <= '0;
            eMdStart <= 1'b0;
            eMdDiv   <= 1'b0;
            mDst     <= '0;
            mRt      <= '0;
            mTnew    <= '0;
            wDst     <= '0;
        end else begin
            wDst <= mDst;

            if (hz.flush) begin
                mDst  <= '0;
                mRt   <= '0;
                mTnew <= '0;
            end else begin
                mDst  <= eDst;
                mRt   <= eRt;
                mTnew <= eTnewDec;
            end

            if (hz.flush || stall) begin
                eDst     <= '0;
                eRs      <= '0;
                eRt      <= '0;
                eTnew    <= '0;
                eMdStart <= 1'b0;
                eMdDiv   <= 1'b0;
            end else begin
                eDst     <= hz.d_dst;
                eRs      <= hz.d_rs;
                eRt      <= hz.d_rt;
                eTnew    <= hz.d_tnew;
                eMdStart <= hz.d_md_start;
                eMdDiv   <= hz.d_md_div;
            end
        end
    end

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdCounter (
        .clk   (clk),
        .reset (reset),
        .start (eMdStart && !hz.flush),
        .isDiv (eMdDiv),
        .busy  (mdBusy)
    );

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Parametrised stall/forward controller for the 5-stage MIPS pipeline (D/E/M/W), replacing fixed opcode decoding with a Tuse/Tnew scoreboard.
- The decoder presents per-instruction register addresses and Tuse/Tnew values at D. The block pipelines destination/Tnew records through E, M and W, and emits the stall and all forwarding selects.
- Adds a multi-cycle HI/LO (mult/div) busy tracker, which the previous generation lacked.
- Sits beside the datapath; drives D-stage hold, E-stage bubble and the forwarding muxes.

## Interface
- AW, 5: register address width.
- TW, 2: Tuse/Tnew field width.
- TUSE_NONE, 2**TW-1: Tuse value meaning "operand not read".
- MULT_CYCLES, 5: mult/multu busy cycles.
- DIV_CYCLES, 10: div/divu busy cycles.
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high; clears all state on the rising edge.
- flush  in  1  kill E and M records (exception/eret).
- d_rs, d_rt  in  AW  D-stage source registers.
- d_tuse_rs, d_tuse_rt  in  TW  cycles from D until the operand is consumed (0 means consumed in D: branch/jr).
- d_dst  in  AW  D-stage destination; 0 means no write.
- d_tnew  in  TW  cycles after entering E until the result exists (jal 0, ALU 1, load 2).
- d_md_use  in  1  D instruction accesses HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- d_md_start, d_md_div  in  1  D instruction starts the MDU; div (1) or mult (0).
- stall  out  1  hold PC/D, bubble E.
- fwd_rs_d, fwd_rt_d  out  2  D forwarding select.
- fwd_rs_e, fwd_rt_e  out  2  E forwarding select.
- fwd_rt_m  out  2  M store-data forwarding select.
- md_busy  out  1  MDU counter nonzero.

## Operation
- Forward encoding: 0 = register file / pipeline value, 1 = M result, 2 = W result, 3 = E result (D only; jal PC+8).
- Per-stage records:
  - E holds {dst, tnew, rs, rt, md_start, md_div}.
  - M holds {dst, tnew, rt}.
  - W holds {dst}.
- Normal advance:
  - E ← D with tnew_e = d_tnew.
  - M ← E with tnew_m = sat(tnew_e − 1), floor 0.
  - W ← M.
- Register 0 never matches: no stall, no forward.
- Data stall when any of the following holds:
  - d_rs ≠ 0, d_tuse_rs ≠ TUSE_NONE, and either (e_dst = d_rs and d_tuse_rs < tnew_e) or (m_dst = d_rs and d_tuse_rs < tnew_m).
  - The same conditions with rt in place of rs.
- MDU stall: d_md_use and (e_md_start or md_cnt ≠ 0).
- stall = data stall OR MDU stall. Combinational, same cycle.
- On stall: E loads a bubble (dst 0, tnew 0, md_start 0); M and W advance normally.
- D forwarding, priority E > M > W:
  - 3 if e_dst matches and tnew_e = 0.
  - 1 if m_dst matches and tnew_m = 0.
  - 2 if w_dst matches.
  - Otherwise 0.
- E forwarding, priority M > W: 1 if m_dst = e_rs/e_rt and tnew_m = 0; 2 if w_dst matches.
- fwd_rt_m: 2 if w_dst = m_rt ≠ 0, else 0.
- Forwarding outputs are valid regardless of stall. The datapath ignores D selects while stalled.
- MDU counter:
  - On the edge where e_md_start = 1, md_cnt ← e_md_div ? DIV_CYCLES : MULT_CYCLES.
  - Otherwise it decrements while nonzero.
- flush:
  - Clears the E and M records to bubbles on the next edge.
  - A killed e_md_start does not load md_cnt.
  - A counter already running continues.
- flush and stall in the same cycle: flush wins; E and M become bubbles.

## Timing
- Reset values:
  - All records 0; md_cnt 0.
  - stall 0, md_busy 0, all fwd_* 0.
- stall and fwd_* are combinational from inputs and registered state; zero latency.
- Load-use: a load in E followed by an ALU consumer in D gives 1 stall cycle.
- Load in E followed by a branch consumer in D gives 2 stall cycles:
  - Cycle 1: load in E, tnew_e = 2.
  - Cycle 2: load in M, tnew_m = 1 > Tuse 0.
- ALU in E followed by a branch in D gives 1 stall, then fwd = 1 from M.
- md_busy is high for exactly N cycles after the E cycle of the start instruction (N = MULT_CYCLES or DIV_CYCLES).
- A D-stage MDU user is released on the first cycle with md_cnt = 0 and no start in E.
- Reset asserted mid-divide clears md_cnt; md_busy drops the next cycle.

## Structure
- Package hazard_pkg holds:
  - FWD_RF, FWD_M, FWD_W, FWD_E.
  - TNEW_JAL, TNEW_ALU, TNEW_LOAD.
  - TUSE_NONE.
- Sub-module md_busy_counter (parameters MULT_CYCLES, DIV_CYCLES): load/decrement counter; outputs md_cnt ≠ 0.
- Stage records are plain registers in hazard_tracker. Match/compare logic is a shared function per stage.

## Test plan
- lw $3 in E (tnew 2), D = addu reading $3 (Tuse 1):
  - 1 cycle stall = 1.
  - Next cycle, the consumer is in E with fwd_rs_e = 1? No: the load is in W by then, so fwd_rs_e = 2.
- ori $5 in E, D = beq $5,$0 (Tuse 0):
  - stall = 1 for 1 cycle.
  - Then fwd_rs_d = 1, fwd_rt_d = 0.
- jal in E (dst 31, tnew 0), D = jr $31: stall = 0, fwd_rs_d = 3.
- addu $0 in E, D reads $0: stall = 0, all fwd = 0.
- div in E, mflo in D:
  - stall for 11 cycles total (1 start cycle + DIV_CYCLES = 10).
  - md_busy high for 10 cycles.
- lw $7 in E, D uses $7, flush asserted: next cycle E and M are bubbles, stall = 0, fwd = 0.
